// File: rtl/serial_pattern_ctrl_pkg.sv
// Shared types and default widths for the serial pattern controller.
package serial_pattern_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_PAT_MAX = 8;
    localparam int DEF_CNT_W   = 8;
    localparam int LEN_W       = $clog2(DEF_PAT_MAX + 1);
    localparam int IDX_W       = $clog2(DEF_DATA_W);

endpackage

// File: rtl/serial_pattern_ctrl_matcher.sv
// Bit-serial pattern matcher: shift history, fill counter and masked compare.
module pattern_matcher
    import serial_pattern_pkg::*;
#(
    parameter int PAT_MAX = DEF_PAT_MAX,
    parameter int LW      = $clog2(PAT_MAX + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               bit_vld,
    input  logic               bit_in,
    input  logic [PAT_MAX-1:0] pattern,
    input  logic [LW-1:0]      len,
    input  logic               overlap,
    input  logic               clr,
    output logic               match
);

    logic [PAT_MAX-1:0] hist_q, hist_d, hist_next;
    logic [LW-1:0]      fill_q, fill_d, fill_next;

    always_comb begin
        hist_next = (hist_q << 1) | PAT_MAX'(bit_in);
        fill_next = (fill_q == LW'(PAT_MAX)) ? fill_q : fill_q + 1'b1;

        match = 1'b0;
        if (bit_vld && (fill_next >= len)) begin
            match = 1'b1;
            for (int i = 0; i < PAT_MAX; i++) begin
                if ((i < int'(len)) && (hist_next[i] != pattern[i])) begin
                    match = 1'b0;
                end
            end
        end

        // Non-overlapping mode forgets the matched bits by emptying the fill count
        hist_d = hist_q;
        fill_d = fill_q;
        if (clr) begin
            hist_d = '0;
            fill_d = '0;
        end else if (bit_vld) begin
            hist_d = hist_next;
            fill_d = (match && !overlap) ? '0 : fill_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/serial_pattern_ctrl.sv
// Word-in, bit-serial pattern detection controller with runtime configuration,
// saturating match counter and registered handshake/status outputs.
module serial_pattern_ctrl
    import serial_pattern_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int PAT_MAX = DEF_PAT_MAX,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cfg_we,
    input  logic [PAT_MAX-1:0]           cfg_pattern,
    input  logic [$clog2(PAT_MAX+1)-1:0] cfg_len,
    input  logic                         cfg_overlap,
    input  logic                         cfg_msb_first,
    input  logic                         cnt_clr,
    input  logic                         in_valid,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         in_ready,
    output logic                         busy,
    output logic                         match_pulse,
    output logic [CNT_W-1:0]             match_count,
    output logic                         done,
    output logic                         cfg_err
);

    localparam int LW = $clog2(PAT_MAX + 1);
    localparam int IW = $clog2(DATA_W);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [PAT_MAX-1:0]  pat_q, pat_d;
    logic [LW-1:0]       len_q, len_d;
    logic                ovl_q, ovl_d;
    logic                msb_q, msb_d;
    logic                in_ready_q, in_ready_d;
    logic                busy_q, busy_d;
    logic                match_pulse_q, match_pulse_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                done_q, done_d;
    logic                cfg_err_q, cfg_err_d;

    logic                cfg_ok, bit_vld, bit_in, last_bit, match;
    logic [IW-1:0]       sel;

    always_comb begin
        cfg_ok   = cfg_we && (state_q == ST_IDLE) && (cfg_len != '0) && (cfg_len <= LW'(PAT_MAX));
        bit_vld  = (state_q == ST_SHIFT);
        sel      = msb_q ? (IW'(DATA_W - 1) - idx_q) : idx_q;
        bit_in   = word_q[sel];
        last_bit = (idx_q == IW'(DATA_W - 1));

        state_d = state_q;
        word_d  = word_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_SHIFT;
                    word_d  = in_data;
                    idx_d   = '0;
                end
            end
            ST_SHIFT: begin
                idx_d = idx_q + 1'b1;
                if (last_bit) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // A write accepted alongside a word lands on the same edge, so it governs that word
        pat_d = pat_q;
        len_d = len_q;
        ovl_d = ovl_q;
        msb_d = msb_q;
        if (cfg_ok) begin
            pat_d = cfg_pattern;
            len_d = cfg_len;
            ovl_d = cfg_overlap;
            msb_d = cfg_msb_first;
        end

        in_ready_d    = (state_d == ST_IDLE);
        busy_d        = (state_d != ST_IDLE);
        done_d        = (state_q == ST_SHIFT) && last_bit;
        match_pulse_d = match;
        cfg_err_d     = cfg_we && !cfg_ok;

        count_d = count_q;
        if (cnt_clr) begin
            count_d = '0;
        end else if (match && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    pattern_matcher #(
        .PAT_MAX (PAT_MAX),
        .LW      (LW)
    ) u_matcher (
        .clk     (clk),
        .reset   (reset),
        .bit_vld (bit_vld),
        .bit_in  (bit_in),
        .pattern (pat_q),
        .len     (len_q),
        .overlap (ovl_q),
        .clr     (cfg_ok),
        .match   (match)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            word_q        <= '0;
            idx_q         <= '0;
            pat_q         <= '0;
            len_q         <= LW'(1);
            ovl_q         <= 1'b0;
            msb_q         <= 1'b1;
            in_ready_q    <= 1'b1;
            busy_q        <= 1'b0;
            match_pulse_q <= 1'b0;
            count_q       <= '0;
            done_q        <= 1'b0;
            cfg_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            word_q        <= word_d;
            idx_q         <= idx_d;
            pat_q         <= pat_d;
            len_q         <= len_d;
            ovl_q         <= ovl_d;
            msb_q         <= msb_d;
            in_ready_q    <= in_ready_d;
            busy_q        <= busy_d;
            match_pulse_q <= match_pulse_d;
            count_q       <= count_d;
            done_q        <= done_d;
            cfg_err_q     <= cfg_err_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign busy        = busy_q;
    assign match_pulse = match_pulse_q;
    assign match_count = count_q;
    assign done        = done_q;
    assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_serial_pattern_ctrl.sv
// Scoreboard bench for serial_pattern_ctrl: a bit-queue reference model predicts
// each word's match positions and final count; a monitor checks them at done.
module tb_serial_pattern_ctrl;
    import serial_pattern_pkg::*;

    localparam int DW   = 8;
    localparam int PM   = 8;
    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic             clk, reset;
    logic             cfg_we, cfg_overlap, cfg_msb_first, cnt_clr, in_valid;
    logic [PM-1:0]    cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic [DW-1:0]    in_data;
    logic             in_ready, busy, match_pulse, done, cfg_err;
    logic [CW-1:0]    match_count;

    serial_pattern_ctrl #(.DATA_W(DW), .PAT_MAX(PM), .CNT_W(CW)) dut (
        .clk           (clk),
        .reset         (reset),
        .cfg_we        (cfg_we),
        .cfg_pattern   (cfg_pattern),
        .cfg_len       (cfg_len),
        .cfg_overlap   (cfg_overlap),
        .cfg_msb_first (cfg_msb_first),
        .cnt_clr       (cnt_clr),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .busy          (busy),
        .match_pulse   (match_pulse),
        .match_count   (match_count),
        .done          (done),
        .cfg_err       (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int            acc;
        logic [DW-1:0] mask;
        int            count;
    } exp_t;
    exp_t sb[$];

    // Reference model: the bits seen since the last clear, newest at the back
    logic [PM-1:0] m_pat;
    int            m_len;
    bit            m_ovl, m_msb;
    bit            m_hist[$];
    int            m_count;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic void modelReset();
        m_pat = '0; m_len = 1; m_ovl = 1'b0; m_msb = 1'b1;
        m_hist.delete();
        m_count = 0;
    endfunction

    function automatic void modelCfg(input logic [PM-1:0] pat, input int len, input bit ovl, input bit msb);
        m_pat = pat; m_len = len; m_ovl = ovl; m_msb = msb;
        m_hist.delete();
    endfunction

    function automatic exp_t modelWord(input logic [DW-1:0] data, input int clr_at, input int acc);
        exp_t e;
        bit   b, hit;
        e.acc  = acc;
        e.mask = '0;
        for (int i = 0; i < DW; i++) begin
            b = m_msb ? data[DW-1-i] : data[i];
            m_hist.push_back(b);
            if (m_hist.size() > PM) void'(m_hist.pop_front());
            hit = (m_hist.size() >= m_len);
            if (hit) begin
                for (int j = 0; j < m_len; j++) begin
                    if (m_hist[m_hist.size() - 1 - j] != m_pat[j]) hit = 1'b0;
                end
            end
            if (hit) begin
                e.mask[i] = 1'b1;
                if (!m_ovl) m_hist.delete();
            end
            if (clr_at == i) m_count = 0;
            else if (hit && m_count < CMAX) m_count++;
        end
        e.count = m_count;
        return e;
    endfunction

    // Monitor: attribute pulses to the oldest outstanding word, judge it at done
    logic [DW-1:0] seen = '0;
    int            mon_idx;
    exp_t          mon_e;
    always @(negedge clk) begin
        if (!reset) begin
            if (match_pulse) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_match", 1, 0);
                end else begin
                    mon_idx = cyc - sb[0].acc - 1;
                    if (mon_idx >= 0 && mon_idx < DW) seen[mon_idx] = 1'b1;
                    else checkOutput("stray_match_offset", mon_idx, 0);
                end
            end
            if (done) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_done", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    checkOutput("done_cycle", cyc, mon_e.acc + DW);
                    checkOutput("match_mask", int'(seen), int'(mon_e.mask));
                    checkOutput("match_count", int'(match_count), mon_e.count);
                    seen = '0;
                end
            end
        end
    end

    task automatic waitReady();
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("in_ready_wait", int'(in_ready), 1);
    endtask

    task automatic waitDrain();
        int n = 0;
        while (sb.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("scoreboard_drain", sb.size(), 0);
    endtask

    task automatic applyStimulus(input logic [DW-1:0] data, input int clr_at, input bit with_cfg,
                                 input logic [PM-1:0] pat, input int len, input bit ovl, input bit msb);
        exp_t e;
        waitReady();
        in_valid = 1'b1;
        in_data  = data;
        if (with_cfg) begin
            cfg_we = 1'b1; cfg_pattern = pat; cfg_len = LEN_W'(len);
            cfg_overlap = ovl; cfg_msb_first = msb;
            if (len >= 1 && len <= PM) modelCfg(pat, len, ovl, msb);
        end
        e = modelWord(data, clr_at, cyc + 1);
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        in_data  = DW'($urandom);
        if (clr_at >= 0) begin
            repeat (clr_at) @(posedge clk);
            @(negedge clk);
            cnt_clr = 1'b1;
            @(posedge clk);
            #1 cnt_clr = 1'b0;
        end
    endtask

    task automatic cfgWrite(input logic [PM-1:0] pat, input int len, input bit ovl, input bit msb, input bit in_idle);
        bit acc;
        if (in_idle) waitReady();
        else @(negedge clk);
        cfg_we = 1'b1; cfg_pattern = pat; cfg_len = LEN_W'(len);
        cfg_overlap = ovl; cfg_msb_first = msb;
        acc = in_idle && len >= 1 && len <= PM;
        if (acc) modelCfg(pat, len, ovl, msb);
        @(posedge clk);
        #1 cfg_we = 1'b0;
        @(negedge clk);
        checkOutput("cfg_err", int'(cfg_err), acc ? 0 : 1);
    endtask

    task automatic checkReset();
        checkOutput("rst_in_ready", int'(in_ready), 1);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_match_pulse", int'(match_pulse), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_cfg_err", int'(cfg_err), 0);
        checkOutput("rst_match_count", int'(match_count), 0);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int r, clr;
        reset = 1'b1; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0;
        cfg_overlap = 1'b0; cfg_msb_first = 1'b1; cnt_clr = 1'b0;
        in_valid = 1'b0; in_data = '0;
        modelReset();
        repeat (3) @(posedge clk);
        #1 checkReset();
        @(negedge clk) reset = 1'b0;

        $display("[TB] directed: non-overlap, overlap, cross-word");
        cfgWrite(8'b10101, 5, 1'b0, 1'b1, 1'b1);
        applyStimulus(8'hAA, -1, 1'b0, '0, 0, 1'b0, 1'b0);
        cfgWrite(8'b10101, 5, 1'b1, 1'b1, 1'b1);
        applyStimulus(8'hAA, -1, 1'b0, '0, 0, 1'b0, 1'b0);
        cfgWrite(8'b1001, 4, 1'b1, 1'b1, 1'b1);
        applyStimulus(8'h01, -1, 1'b0, '0, 0, 1'b0, 1'b0);
        applyStimulus(8'h3F, -1, 1'b0, '0, 0, 1'b0, 1'b0);

        $display("[TB] directed: rejected config writes");
        cfgWrite(8'b10101, 5, 1'b0, 1'b1, 1'b1);
        applyStimulus(8'hAA, -1, 1'b0, '0, 0, 1'b0, 1'b0);
        cfgWrite(8'hFF, 3, 1'b1, 1'b0, 1'b0);
        cfgWrite(8'hFF, 0, 1'b1, 1'b0, 1'b1);
        cfgWrite(8'hFF, 9, 1'b1, 1'b0, 1'b1);
        applyStimulus(8'hAA, -1, 1'b0, '0, 0, 1'b0, 1'b0);

        $display("[TB] directed: config coincident with word, LSB first");
        applyStimulus(8'hAA, -1, 1'b1, 8'b10101, 5, 1'b1, 1'b1);
        applyStimulus(8'h0D, -1, 1'b1, 8'b101, 3, 1'b1, 1'b0);

        $display("[TB] directed: counter saturation and clear");
        cfgWrite(8'b1, 1, 1'b1, 1'b1, 1'b1);
        repeat (33) applyStimulus(8'hFF, -1, 1'b0, '0, 0, 1'b0, 1'b0);
        waitDrain();
        checkOutput("count_saturated", int'(match_count), CMAX);
        applyStimulus(8'hFF, 7, 1'b0, '0, 0, 1'b0, 1'b0);
        applyStimulus(8'hFF, 3, 1'b0, '0, 0, 1'b0, 1'b0);

        $display("[TB] random words and configs");
        repeat (40) begin
            r   = $urandom_range(0, 9);
            clr = ($urandom_range(0, 5) == 0) ? $urandom_range(0, DW - 1) : -1;
            if (r == 0)
                cfgWrite(PM'($urandom), $urandom_range(1, PM), 1'($urandom), 1'($urandom), 1'b1);
            else if (r == 1)
                cfgWrite(PM'($urandom), ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(PM + 1, 15),
                         1'($urandom), 1'($urandom), 1'b1);
            else
                applyStimulus(DW'($urandom), clr, r == 2, PM'($urandom), $urandom_range(1, PM),
                              1'($urandom), 1'($urandom));
        end
        waitDrain();

        $display("[TB] directed: reset in the middle of a word");
        cfgWrite(8'b10101, 5, 1'b0, 1'b1, 1'b1);
        waitReady();
        in_valid = 1'b1;
        in_data  = 8'hAA;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 checkReset();
        modelReset();
        @(negedge clk) reset = 1'b0;
        repeat (12) @(negedge clk);
        applyStimulus(8'hAA, -1, 1'b0, '0, 0, 1'b0, 1'b0);
        waitDrain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
